// File: rtl/iodev_pkg.sv
// iodev_pkg: shared FSM encodings, defaults and byte width for the input-device transmitter
package iodev_pkg;

    localparam int BYTE_W          = 8;
    localparam int DEF_DEPTH       = 8;
    localparam int DEF_TIMEOUT_CYC = 255;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: pointer-based circular byte buffer; power-of-2 depth so pointers wrap naturally
module byte_fifo
    import iodev_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = BYTE_W
) (
    input  logic             g_clk,
    input  logic             g_clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [4:0]       count,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // full never pushes and empty never pops, whatever the caller asks
    assign do_push = push && (count < 5'(DEPTH));
    assign do_pop  = pop && (count != 5'd0);
    assign head    = mem[rd_ptr];

    // pointer and occupancy bookkeeping
    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 5'd0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + 5'(do_push) - 5'(do_pop);
        end
    end

    // storage needs no reset; only the pointers define validity
    always_ff @(posedge g_clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/input_dev_tx.sv
// input_dev_tx: FIFO-buffered byte source driving the processor's four-phase input handshake
// Optional watchdog enabled by defining IODEV_TIMEOUT_EN.
module input_dev_tx
    import iodev_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              g_clk,
    input  logic              g_clr,
    input  logic              src_valid,
    input  logic [BYTE_W-1:0] src_data,
    output logic              src_ready,
    output logic              in_dev_hs,
    output logic [BYTE_W-1:0] input_bus,
    input  logic              in_dev_ack,
    output logic [4:0]        fifo_count,
    output logic [7:0]        tx_count,
    output logic              timeout_err,
    input  logic              err_clr
);

    state_t            state;
    logic [BYTE_W-1:0] head;
    logic              load;

    assign src_ready = fifo_count < 5'(DEPTH);
    // a load happens from IDLE or RELEASE once ack is low and a byte is waiting
    assign load = (fifo_count != 5'd0) && !in_dev_ack && (state == IDLE || state == RELEASE);

    byte_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_fifo (
        .g_clk (g_clk),
        .g_clr (g_clr),
        .push  (src_valid && src_ready),
        .pop   (load),
        .din   (src_data),
        .count (fifo_count),
        .head  (head)
    );

`ifdef IODEV_TIMEOUT_EN
    logic [7:0] wd;
    logic       waiting;
    logic       wd_expire;

    assign waiting   = (state == PRESENT && !in_dev_ack) || (state == RELEASE && in_dev_ack);
    assign wd_expire = waiting && (wd == 8'(TIMEOUT_CYC - 1));

    // watchdog counts stalled cycles and restarts on any state change
    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) wd <= 8'd0;
        else        wd <= (waiting && !wd_expire) ? wd + 8'd1 : 8'd0;
    end

    // sticky error flag; a clear wins over a coincident expiry
    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr)         timeout_err <= 1'b0;
        else if (err_clr)   timeout_err <= 1'b0;
        else if (wd_expire) timeout_err <= 1'b1;
    end
`else
    logic unused_cfg;

    assign timeout_err = 1'b0;
    assign unused_cfg  = err_clr | (TIMEOUT_CYC == 0);
`endif

    // handshake FSM with registered hs, bus and delivery count
    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            state     <= IDLE;
            in_dev_hs <= 1'b0;
            input_bus <= '0;
            tx_count  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        input_bus <= head;
                        in_dev_hs <= 1'b1;
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (in_dev_ack) begin
                        in_dev_hs <= 1'b0;
                        tx_count  <= tx_count + 8'd1;
                        state     <= RELEASE;
                    end
`ifdef IODEV_TIMEOUT_EN
                    else if (wd_expire) begin
                        in_dev_hs <= 1'b0;
                        state     <= RELEASE;
                    end
`endif
                end
                RELEASE: begin
                    if (load) begin
                        input_bus <= head;
                        in_dev_hs <= 1'b1;
                        state     <= PRESENT;
                    end else if (!in_dev_ack) begin
                        state <= IDLE;
                    end
`ifdef IODEV_TIMEOUT_EN
                    else if (wd_expire) begin
                        state <= IDLE;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_input_dev_tx.sv
// tb_input_dev_tx: directed vector table plus hand sequences for input_dev_tx
module tb_input_dev_tx;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       ack;
        logic       hs;
        logic [7:0] bus;
        logic [4:0] fc;
        logic [7:0] tx;
        logic       rdy;
    } vec_t;

    logic       g_clk = 1'b0;
    logic       g_clr = 1'b0;
    logic       src_valid = 1'b0;
    logic [7:0] src_data = 8'd0;
    logic       src_ready;
    logic       in_dev_hs;
    logic [7:0] input_bus;
    logic       in_dev_ack = 1'b0;
    logic [4:0] fifo_count;
    logic [7:0] tx_count;
    logic       timeout_err;
    logic       err_clr = 1'b0;

    int   checks = 0;
    int   failures = 0;
    vec_t tbl[$];

    input_dev_tx #(.DEPTH(8), .TIMEOUT_CYC(10)) dut (
        .g_clk       (g_clk),
        .g_clr       (g_clr),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_ready   (src_ready),
        .in_dev_hs   (in_dev_hs),
        .input_bus   (input_bus),
        .in_dev_ack  (in_dev_ack),
        .fifo_count  (fifo_count),
        .tx_count    (tx_count),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    always #5 g_clk = ~g_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic ack, input logic hs,
                       input logic [7:0] bus, input logic [4:0] fc, input logic [7:0] tx, input logic rdy);
        vec_t r;
        r.v = v; r.d = d; r.ack = ack; r.hs = hs; r.bus = bus; r.fc = fc; r.tx = tx; r.rdy = rdy;
        tbl.push_back(r);
    endtask

    task automatic cyc(input logic v, input logic [7:0] d, input logic ack);
        src_valid = v;
        src_data = d;
        in_dev_ack = ack;
        @(posedge g_clk);
        #1;
    endtask

    initial begin
        // single byte with a slow acknowledge
        add(1, 8'hA5, 0, 0, 8'h00, 1, 0, 1);
        add(0, 8'h00, 0, 1, 8'hA5, 0, 0, 1);
        add(0, 8'h00, 0, 1, 8'hA5, 0, 0, 1);
        add(0, 8'h00, 1, 0, 8'hA5, 0, 1, 1);
        add(0, 8'h00, 1, 0, 8'hA5, 0, 1, 1);
        add(0, 8'h00, 0, 0, 8'hA5, 0, 1, 1);
        // fill to full while a stale ack blocks loading; 0x09 is refused
        for (int i = 1; i <= 8; i++) add(1, 8'(i), 1, 0, 8'hA5, 5'(i), 1, i < 8);
        add(1, 8'h09, 1, 0, 8'hA5, 8, 1, 0);
        add(0, 8'h00, 1, 0, 8'hA5, 8, 1, 0);
        // zero-latency acknowledge drains 0x01..0x08 at two cycles per byte
        for (int k = 1; k <= 8; k++) begin
            add(0, 8'h00, 0, 1, 8'(k), 5'(8 - k), 8'(k), 1);
            add(0, 8'h00, 1, 0, 8'(k), 5'(8 - k), 8'(k + 1), 1);
        end
        add(0, 8'h00, 0, 0, 8'h08, 0, 9, 1);
        // push and pop on the same edge keep the count
        add(1, 8'h11, 0, 0, 8'h08, 1, 9, 1);
        add(1, 8'h22, 0, 1, 8'h11, 1, 9, 1);
        add(0, 8'h00, 1, 0, 8'h11, 1, 10, 1);
        add(0, 8'h00, 0, 1, 8'h22, 0, 10, 1);
        add(0, 8'h00, 1, 0, 8'h22, 0, 11, 1);
        add(0, 8'h00, 0, 0, 8'h22, 0, 11, 1);

        #3;
        chk("rst_hs", 32'(in_dev_hs), 0);
        chk("rst_bus", 32'(input_bus), 0);
        chk("rst_fc", 32'(fifo_count), 0);
        chk("rst_tx", 32'(tx_count), 0);
        chk("rst_err", 32'(timeout_err), 0);
        chk("rst_rdy", 32'(src_ready), 1);
        #9 g_clr = 1'b1;

        foreach (tbl[i]) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].ack);
            chk($sformatf("v%0d_hs", i), 32'(in_dev_hs), 32'(tbl[i].hs));
            chk($sformatf("v%0d_bus", i), 32'(input_bus), 32'(tbl[i].bus));
            chk($sformatf("v%0d_fc", i), 32'(fifo_count), 32'(tbl[i].fc));
            chk($sformatf("v%0d_tx", i), 32'(tx_count), 32'(tbl[i].tx));
            chk($sformatf("v%0d_rdy", i), 32'(src_ready), 32'(tbl[i].rdy));
        end

        // stalled handshake: 0x55 presented, 0x66 queued, ack never rises
        cyc(1, 8'h55, 0);
        cyc(1, 8'h66, 0);
        chk("wd_hs_up", 32'(in_dev_hs), 1);
        chk("wd_bus55", 32'(input_bus), 32'h55);
        repeat (9) begin
            cyc(0, 8'h00, 0);
            chk("wd_hs_hold", 32'(in_dev_hs), 1);
        end
        cyc(0, 8'h00, 0);
`ifdef IODEV_TIMEOUT_EN
        chk("wd_hs_drop", 32'(in_dev_hs), 0);
        chk("wd_err_set", 32'(timeout_err), 1);
        chk("wd_tx_keep", 32'(tx_count), 11);
        err_clr = 1'b1;
        cyc(0, 8'h00, 0);
        err_clr = 1'b0;
        chk("wd_err_clr", 32'(timeout_err), 0);
        chk("wd_next_hs", 32'(in_dev_hs), 1);
        chk("wd_next_bus", 32'(input_bus), 32'h66);
`else
        chk("nowd_hs", 32'(in_dev_hs), 1);
        chk("nowd_err", 32'(timeout_err), 0);
        chk("nowd_bus", 32'(input_bus), 32'h55);
        chk("nowd_tx", 32'(tx_count), 11);
`endif

        // reset mid-transfer with bytes queued: outputs clear without a clock edge
        repeat (3) cyc(1, 8'h31, 0);
        src_valid = 1'b0;
        chk("mid_hs_before", 32'(in_dev_hs), 1);
        g_clr = 1'b0;
        #2;
        chk("mid_hs", 32'(in_dev_hs), 0);
        chk("mid_fc", 32'(fifo_count), 0);
        chk("mid_tx", 32'(tx_count), 0);
        chk("mid_bus", 32'(input_bus), 0);
        chk("mid_err", 32'(timeout_err), 0);
        #1 g_clr = 1'b1;

        // recovery after reset: a fresh byte is delivered
        cyc(1, 8'h99, 0);
        chk("rec_fc", 32'(fifo_count), 1);
        cyc(0, 8'h00, 0);
        chk("rec_hs", 32'(in_dev_hs), 1);
        chk("rec_bus", 32'(input_bus), 32'h99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
